pes_count_monitor: RTL and testbench

PES_COUNT_MONITOR -- requirements
Module: pes_count_monitor

---
 rtl/pes_cntmon_pkg.sv | 10 +
 rtl/pes_sync2.sv | 26 ++
 rtl/pes_count_monitor.sv | 138 +++++++++++++
 tb/tb_pes_count_monitor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pes_cntmon_pkg.sv
// Shared types and defaults for the 2-bit count-sequence monitor.
package pes_cntmon_pkg;

  typedef enum logic [1:0] {ACQ, HUNT, LOCKED} cntmon_state_e;

  typedef logic [1:0] cnt2_t;

  localparam int unsigned LOCK_N_DEFAULT = 4;

endpackage

// File: rtl/pes_sync2.sv
// Two-flop synchroniser with synchronous active-high clear.
module pes_sync2 #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pes_count_monitor.sv
// Monitors a 2-bit ripple count: locks after LOCK_N good steps, counts wraps and errors.
// Define PES_CNTMON_SYNC_EN to place a two-flop synchroniser ahead of the sample register.
module pes_count_monitor
  import pes_cntmon_pkg::*;
#(
  parameter int unsigned LOCK_N = LOCK_N_DEFAULT,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        q_in,
  input  logic              err_clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned GoodW = $clog2(LOCK_N + 1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_N - 1);

  cnt2_t q_src;
  cnt2_t s_q;
  cnt2_t prev_q;
  cnt2_t prev_inc;

`ifdef PES_CNTMON_SYNC_EN
  pes_sync2 #(
    .WIDTH(2)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (q_in),
    .q    (q_src)
  );
`else
  assign q_src = q_in;
`endif

  cntmon_state_e     state_q, state_d;
  logic [GoodW-1:0]  good_q, good_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              step_hold, step_good, step_bad, lock_err;

  assign prev_inc  = prev_q + 2'd1;
  assign step_hold = (s_q == prev_q);
  assign step_good = (s_q == prev_inc);
  assign step_bad  = !step_hold && !step_good;

  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    wrap_pulse_d = 1'b0;
    wrap_count_d = wrap_count_q;
    err_d        = err_q;
    err_count_d  = err_count_q;
    lock_err     = 1'b0;

    unique case (state_q)
      ACQ: begin
        state_d = HUNT;
        good_d  = '0;
      end
      HUNT: begin
        // The locking step never produces a wrap, even when it is 3->0.
        if (step_good) begin
          if (good_q == GoodLast) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end else if (step_bad) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (step_good && (prev_q == 2'd3)) begin
          wrap_pulse_d = 1'b1;
          wrap_count_d = wrap_count_q + 1'b1;
        end else if (step_bad) begin
          state_d  = HUNT;
          good_d   = '0;
          lock_err = 1'b1;
        end
      end
      default: state_d = ACQ;
    endcase

    if (err_clr) begin
      err_d       = 1'b0;
      err_count_d = '0;
    end
    // A new error wins over a coincident clear, leaving a count of one.
    if (lock_err) begin
      err_d = 1'b1;
      if (err_clr) begin
        err_count_d = ERR_W'(1);
      end else if (err_count_q != '1) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q          <= '0;
      prev_q       <= '0;
      state_q      <= ACQ;
      good_q       <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      s_q          <= q_src;
      prev_q       <= s_q;
      state_q      <= state_d;
      good_q       <= good_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_pes_count_monitor.sv
// Bench for pes_count_monitor: directed scenarios plus random stimulus against a sequence model.
module tb_pes_count_monitor;

  localparam int unsigned LOCK_N = 4;
  localparam int unsigned WRAP_W = 8;
  localparam int unsigned ERR_W  = 8;
`ifdef PES_CNTMON_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = 2 + SYNC;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        q_in;
  logic              err_clr;
  logic              locked;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              err;
  logic [ERR_W-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pes_count_monitor #(
    .LOCK_N(LOCK_N),
    .WRAP_W(WRAP_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .err_clr   (err_clr),
    .locked    (locked),
    .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count),
    .err       (err),
    .err_count (err_count)
  );

  // Reference model: the sampled value stream and what each step means for the outputs.
  int m_pipe [2];
  int m_s, m_prev, m_run, m_wc, m_ec;
  bit m_acq, m_locked, m_wp, m_err;

  function automatic void model_update(input bit r, input int q, input bit c);
    bit hold, good, lerr;
    if (r) begin
      m_pipe[0] = 0; m_pipe[1] = 0; m_s = 0; m_prev = 0;
      m_acq = 1; m_run = 0; m_locked = 0; m_wp = 0; m_wc = 0; m_err = 0; m_ec = 0;
      return;
    end
    hold = (m_s == m_prev);
    good = (m_s == (m_prev + 1) % 4);
    lerr = 0;
    m_wp = 0;
    if (m_acq) begin
      m_acq = 0;
    end else if (!m_locked) begin
      if (good) begin
        m_run++;
        if (m_run == LOCK_N) begin m_locked = 1; m_run = 0; end
      end else if (!hold) begin
        m_run = 0;
      end
    end else begin
      if (good && m_prev == 3) begin
        m_wp = 1;
        m_wc = (m_wc + 1) % (1 << WRAP_W);
      end else if (!hold && !good) begin
        m_locked = 0; m_run = 0; lerr = 1;
      end
    end
    if (c) begin m_err = 0; m_ec = 0; end
    if (lerr) begin
      m_err = 1;
      m_ec  = c ? 1 : ((m_ec == (1 << ERR_W) - 1) ? m_ec : m_ec + 1);
    end
    m_prev = m_s;
    if (SYNC > 0) begin
      m_s = m_pipe[1]; m_pipe[1] = m_pipe[0]; m_pipe[0] = q;
    end else begin
      m_s = q;
    end
  endfunction

  task automatic tick(input logic r, input logic [1:0] q, input logic c);
    reset = r; q_in = q; err_clr = c;
    @(posedge clk);
    model_update(r, int'(q), c);
    #1;
  endtask

  task automatic hold_q(input logic [1:0] q, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, q, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 2'(i + 1), 1'(i & 1));
      checks++;
      if ({locked, wrap_pulse, wrap_count, err, err_count} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got l=%b wp=%b wc=%0d e=%b ec=%0d want all 0",
                 i, locked, wrap_pulse, wrap_count, err, err_count);
      end
    end
    tick(1'b0, 2'd2, 1'b0);
    checks++;
    if ({locked, wrap_pulse, wrap_count, err, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_release got l=%b wp=%b wc=%0d e=%b ec=%0d want all 0",
               locked, wrap_pulse, wrap_count, err, err_count);
    end
  endtask

  task automatic test_lock();
    int seq [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
    int first_lock = -1;
    int wp_n = 0;
    int wp_at = -1;
    int mism = 0;
    tick(1'b1, 2'd0, 1'b0);
    tick(1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 2'(seq[i / 3]), 1'b0);
      if (locked === 1'b1 && first_lock < 0) first_lock = i;
      if (wrap_pulse === 1'b1) begin wp_n++; wp_at = i; end
      if (locked !== m_locked || wrap_pulse !== m_wp) mism++;
    end
    checks++;
    if (first_lock != 12 + LAT - 1) begin
      errors++;
      $display("FAIL lock_time got %0d want %0d", first_lock, 12 + LAT - 1);
    end
    checks++;
    if (wp_n != 1 || wp_at != 24 + LAT - 1) begin
      errors++;
      $display("FAIL wrap_pulse_time got n=%0d at %0d want n=1 at %0d", wp_n, wp_at, 24 + LAT - 1);
    end
    checks++;
    if (wrap_count !== 8'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_end got wc=%0d l=%b want wc=1 l=1", wrap_count, locked);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL lock_model got %0d cycle mismatches want 0", mism);
    end
  endtask

  task automatic test_error();
    hold_q(2'd1, 2);
    hold_q(2'd3, LAT);
    checks++;
    if (locked !== 1'b0 || err !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL bad_step got l=%b e=%b ec=%0d want l=0 e=1 ec=1", locked, err, err_count);
    end
    hold_q(2'd0, 2);
    hold_q(2'd1, 2);
    hold_q(2'd2, 2);
    hold_q(2'd3, LAT + 1);
    checks++;
    if (locked !== 1'b1 || err !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL relock got l=%b e=%b ec=%0d want l=1 e=1 ec=1", locked, err, err_count);
    end
  endtask

  task automatic test_err_clr();
    hold_q(2'd0, 2);
    hold_q(2'd1, 2);
    hold_q(2'd2, 2);
    hold_q(2'd0, LAT - 1);
    tick(1'b0, 2'd0, 1'b1);
    checks++;
    if (err !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL clr_with_err got e=%b ec=%0d want e=1 ec=1", err, err_count);
    end
    tick(1'b0, 2'd0, 1'b1);
    checks++;
    if (err !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL clr_alone got e=%b ec=%0d want e=0 ec=0", err, err_count);
    end
  endtask

  task automatic test_wrap_sat();
    logic [1:0] q = 2'd0;
    tick(1'b1, 2'd0, 1'b0);
    tick(1'b1, 2'd0, 1'b0);
    for (int w = 0; w < 256; w++) begin
      for (int k = 1; k <= 4; k++) tick(1'b0, 2'(k), 1'b0);
    end
    hold_q(2'd0, LAT);
    checks++;
    if (wrap_count !== 8'd255 || locked !== 1'b1) begin
      errors++;
      $display("FAIL wrap_255 got wc=%0d l=%b want wc=255 l=1", wrap_count, locked);
    end
    for (int k = 1; k <= 3; k++) tick(1'b0, 2'(k), 1'b0);
    hold_q(2'd0, LAT);
    checks++;
    if (wrap_pulse !== 1'b1 || wrap_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_roll got wp=%b wc=%0d want wp=1 wc=0", wrap_pulse, wrap_count);
    end
    tick(1'b0, 2'd0, 1'b0);
    checks++;
    if (wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wrap_one_cycle got wp=%b want 0", wrap_pulse);
    end
    for (int e = 0; e < 256; e++) begin
      q = q + 2'd2;
      tick(1'b0, q, 1'b0);
      for (int k = 0; k < 4; k++) begin q = q + 2'd1; tick(1'b0, q, 1'b0); end
      if (e == 254) begin
        hold_q(q, LAT);
        checks++;
        if (err_count !== 8'd255) begin
          errors++;
          $display("FAIL err_255 got %0d want 255", err_count);
        end
      end
    end
    hold_q(q, LAT);
    checks++;
    if (err_count !== 8'd255 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_sat got ec=%0d e=%b want ec=255 e=1", err_count, err);
    end
  endtask

  task automatic test_random();
    logic [1:0] q = 2'd0;
    int k;
    tick(1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      if (k >= 4 && k < 8) q = q + 2'd1;
      else if (k >= 8) q = 2'($urandom_range(0, 3));
      tick(1'($urandom_range(0, 99) == 0), q, 1'($urandom_range(0, 15) == 0));
      checks++;
      if (locked !== m_locked || wrap_pulse !== m_wp || wrap_count !== WRAP_W'(m_wc) ||
          err !== m_err || err_count !== ERR_W'(m_ec)) begin
        errors++;
        $display("FAIL random cyc %0d got l=%b wp=%b wc=%0d e=%b ec=%0d want l=%b wp=%b wc=%0d e=%b ec=%0d",
                 i, locked, wrap_pulse, wrap_count, err, err_count,
                 m_locked, m_wp, m_wc, m_err, m_ec);
      end
    end
  endtask

  initial begin
    reset = 1'b1; q_in = 2'd0; err_clr = 1'b0;
    test_reset();
    test_lock();
    test_error();
    test_err_clr();
    test_wrap_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
